// File: rtl/ram_fifo_if.sv
// Handshake and RAM-port bundle for ram_fifo_ctrl: push stream, pop stream and
// the simple dual-port BRAM write/read ports.
interface ram_fifo_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic                  ram_write_en;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  in_valid, in_data, out_ready, ram_dout,
    output in_ready, out_valid, out_data, ram_write_en, ram_waddr, ram_din, ram_raddr
  );

  modport master (
    output in_valid, in_data, out_ready, ram_dout,
    input  in_ready, out_valid, out_data, ram_write_en, ram_waddr, ram_din, ram_raddr
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a 1-cycle-latency BRAM with a 2-entry FWFT output buffer.
// Optional macro RAM_FIFO_LEVEL_EN adds the combinational 'level' occupancy port.
module ram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  ram_fifo_if.slave bus
`ifdef RAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] level
`endif
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW-1:0]         ram_cnt;
  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_ready, out_valid;
  logic                  push, pop, issue;
  logic [2:0]            after_pop;

  assign ram_cnt   = wptr_q - rptr_q;
  assign in_ready  = !rst && (ram_cnt != FULL_CNT);
  assign push      = bus.in_valid && in_ready;
  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid && bus.out_ready;

  // Buffer slots still committed after this cycle's pop; a read may only be
  // issued if its data will find a free slot when it returns next cycle.
  assign after_pop = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue     = (ram_cnt != '0) && (after_pop < 3'd2);

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = head_q;
  assign bus.ram_write_en = push;
  assign bus.ram_waddr    = wptr_q[ADDR_WIDTH-1:0];
  assign bus.ram_din      = bus.in_data;
  assign bus.ram_raddr    = rptr_q[ADDR_WIDTH-1:0];

`ifdef RAM_FIFO_LEVEL_EN
  assign level = {1'b0, ram_cnt}
               + {{(ADDR_WIDTH+1){1'b0}}, rd_pend_q}
               + {{ADDR_WIDTH{1'b0}}, occ_q};
`endif

  always_comb begin
    wptr_d    = wptr_q + {{ADDR_WIDTH{1'b0}}, push};
    rptr_d    = rptr_q + {{ADDR_WIDTH{1'b0}}, issue};
    rd_pend_d = issue;
    head_d    = head_q;
    skid_d    = skid_q;
    occ_d     = occ_q;
    if (pop) begin
      head_d = skid_q;
      occ_d  = occ_q - 2'd1;
    end
    // Returning RAM word lands behind whatever survives the pop.
    if (rd_pend_q) begin
      if (occ_d == 2'd0) head_d = bus.ram_dout;
      else               skid_d = bus.ram_dout;
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_pend_q <= 1'b0;
      occ_q     <= 2'd0;
      head_q    <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_pend_q <= rd_pend_d;
      occ_q     <= occ_d;
      head_q    <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl (ADDR_WIDTH=4, capacity 18) with a behavioural
// BRAM beside it; a negedge monitor checks ordering, FWFT timing and write enables.
module tb_ram_fifo_ctrl;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int CAP = (1 << AW) + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ram_fifo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
`ifdef RAM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
`endif

  ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus)
`ifdef RAM_FIFO_LEVEL_EN
    ,
    .level(level)
`endif
  );

  // BRAM: write on falling edge, registered read with one cycle latency.
  logic [DW-1:0] mem [1 << AW];
  always @(negedge clk) if (bus.ram_write_en) mem[bus.ram_waddr] <= bus.ram_din;
  always @(posedge clk) bus.ram_dout <= mem[bus.ram_raddr];

  int n_chk  = 0;
  int n_pass = 0;
  int n_out  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: words in FIFO order, each tagged with its accept cycle.
  // A word becomes the visible head 3 cycles after acceptance at the earliest.
  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } ent_t;
  ent_t exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      logic exp_v;
      ent_t e;
      exp_v = (exp_q.size() > 0) && (exp_q[0].c <= cyc - 3);
      check("out_valid", bus.out_valid, exp_v);
`ifdef RAM_FIFO_LEVEL_EN
      check("level", level, exp_q.size());
`endif
      check("write_en", bus.ram_write_en, bus.in_valid && bus.in_ready);
      if (bus.ram_write_en) check("ram_din", bus.ram_din, bus.in_data);
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e.d);
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back('{d: bus.in_data, c: cyc});
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc;
    int guard;
    logic [DW-1:0] cur;
    logic v, r;

    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hFF;
    bus.out_ready = 1'b1;

    // Reset state with a push attempt held high.
    repeat (2) @(posedge clk);
    #3;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_write_en", bus.ram_write_en, 1'b0);
    check("rst_waddr", bus.ram_waddr, 0);
    check("rst_raddr", bus.ram_raddr, 0);
    check("rst_out_data", bus.out_data, 0);

    // Scenario 1: single word through an empty FIFO.
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step(1'b0, 8'h00, 1'b1);
      #2;
      check("s1_in_ready", bus.in_ready, 1'b1);
      check("s1_valid", bus.out_valid, k == 3);
      if (k == 3) check("s1_data", bus.out_data, 8'h5A);
    end

    // Scenario 2: fill to capacity with no pops, then drain.
    for (int i = 0; i < 21; i++) begin
      step(1'b1, (i <= 18) ? 8'(i) : 8'h12, 1'b0);
      #2;
      check("s2_in_ready", bus.in_ready, i < CAP);
      if (i >= CAP) check("s2_no_write", bus.ram_write_en, 1'b0);
    end
    base = n_out;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 8'h00, 1'b1);
      #2;
      if (i == 0) check("s2_still_full", bus.in_ready, 1'b0);
      if (i == 1) check("s2_ready_back", bus.in_ready, 1'b1);
    end
    check("s2_count", n_out - base, CAP);
    check("s2_empty", exp_q.size(), 0);

    // Scenario 3: streaming push+pop every cycle across pointer wraps.
    base = n_out;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(i), 1'b1);
      #2;
      check("s3_in_ready", bus.in_ready, 1'b1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
    check("s3_count", n_out - base, 40);

    // Scenario 4: random valid/ready traffic, 1000 words.
    void'($urandom(32'd20240517));
    base = n_out;
    acc = 0;
    guard = 0;
    cur = 8'($urandom);
    while (acc < 1000 && guard < 20000) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      step(v, cur, r);
      #2;
      if (v && bus.in_ready) begin
        acc++;
        cur = 8'($urandom);
      end
      guard++;
    end
    check("s4_accepted", acc, 1000);
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      step(1'b0, 8'h00, 1'b1);
      guard++;
    end
    step(1'b0, 8'h00, 1'b1);
    check("s4_drained", exp_q.size(), 0);
    check("s4_count", n_out - base, 1000);

    // Scenario 5: reset while words are queued.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("s5_valid_drop", bus.out_valid, 1'b0);
    check("s5_ready_drop", bus.in_ready, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.out_ready = 1'b1;
    base = n_out;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) step(1'b0, 8'h00, 1'b1);
      #2;
      check("s5_valid", bus.out_valid, k == 3);
      if (k == 3) check("s5_data", bus.out_data, 8'hA5);
    end
    check("s5_count", n_out - base, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
